// File: rtl/dotprod_pkg.sv
// Shared constants and types for the dot-product sequencer and its MAC datapath.
package dotprod_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int VEC_LEN_DEF    = 32;
  localparam int ADDR_WIDTH_DEF = 5;

  // Cycles from rd_en to dout at the operand memory read ports.
  localparam int RD_LATENCY = 1;

  // Product width plus one bit per address bit: VEC_LEN full-scale products cannot overflow.
  function automatic int acc_width(input int data_width, input int addr_width);
    return 2 * data_width + addr_width;
  endfunction

  localparam int ACC_WIDTH_DEF = acc_width(DATA_WIDTH_DEF, ADDR_WIDTH_DEF);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_FLUSH = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

endpackage

// File: rtl/dot_product_sequencer_if.sv
// Command, operand-memory read and result handshake bundle of the dot-product sequencer.
interface dot_product_sequencer_if #(
  parameter int DATA_WIDTH = dotprod_pkg::DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = dotprod_pkg::ADDR_WIDTH_DEF,
  parameter int ACC_WIDTH  = dotprod_pkg::acc_width(DATA_WIDTH, ADDR_WIDTH)
);

  logic                  start;
  logic [ADDR_WIDTH:0]   len;
  logic                  mem_ready;
  logic                  rd_en_a;
  logic [ADDR_WIDTH-1:0] rd_addr_a;
  logic [DATA_WIDTH-1:0] dout_a;
  logic                  rd_en_b;
  logic [ADDR_WIDTH-1:0] rd_addr_b;
  logic [DATA_WIDTH-1:0] dout_b;
  logic                  busy;
  logic                  cfg_err;
  logic [ACC_WIDTH-1:0]  result;
  logic                  result_valid;
  logic                  result_ready;

  // Sequencer side.
  modport slave (
    input  start, len, mem_ready, dout_a, dout_b, result_ready,
    output rd_en_a, rd_addr_a, rd_en_b, rd_addr_b, busy, cfg_err, result, result_valid
  );

  // Controller / memory / consumer side.
  modport master (
    output start, len, mem_ready, dout_a, dout_b, result_ready,
    input  rd_en_a, rd_addr_a, rd_en_b, rd_addr_b, busy, cfg_err, result, result_valid
  );

endinterface

// File: rtl/dot_mac_unit.sv
// Multiply-accumulate datapath: registered product, accumulator and read/product valid chain.
module dot_mac_unit
  import dotprod_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ACC_WIDTH  = ACC_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,       // next accumulate starts a new sum
  input  logic                  data_valid,  // a read is issued this cycle; data returns RD_LATENCY later
  input  logic [DATA_WIDTH-1:0] dout_a,
  input  logic [DATA_WIDTH-1:0] dout_b,
  output logic [ACC_WIDTH-1:0]  acc,
  output logic                  pipe_empty   // nothing left to accumulate after this clock edge
);

  localparam int PROD_W = 2 * DATA_WIDTH;

  // vld_q[RD_LATENCY-1]: read data present; vld_q[RD_LATENCY]: product register valid.
  logic [RD_LATENCY:0]  vld_q, vld_d;
  logic [PROD_W-1:0]    prod_q, prod_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic                 pend_q, pend_d;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    vld_d  = {vld_q[RD_LATENCY-1:0], data_valid};
    prod_d = prod_q;
    acc_d  = acc_q;
    pend_d = pend_q;
    if (vld_q[RD_LATENCY-1]) begin
      prod_d = PROD_W'(dout_a) * PROD_W'(dout_b);
    end
    // The old sum stays visible until the first product of the new run overwrites it.
    if (vld_q[RD_LATENCY]) begin
      acc_d  = (pend_q ? '0 : acc_q) + ACC_WIDTH'(prod_q);
      pend_d = 1'b0;
    end
    if (clear) begin
      pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!rst_n) begin
      vld_q  <= '0;
      prod_q <= '0;
      acc_q  <= '0;
      pend_q <= 1'b0;
    end else begin
      vld_q  <= vld_d;
      prod_q <= prod_d;
      acc_q  <= acc_d;
      pend_q <= pend_d;
    end
  end

  assign acc        = acc_q;
  assign pipe_empty = !data_valid && (vld_q[RD_LATENCY-1:0] == '0);

endmodule

// File: rtl/dot_product_sequencer.sv
// Streams matched addresses to operand memories A/B, accumulates the element products
// and returns the dot product through a valid/ready result handshake.
module dot_product_sequencer
  import dotprod_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int VEC_LEN    = VEC_LEN_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int ACC_WIDTH  = acc_width(DATA_WIDTH, ADDR_WIDTH)
) (
  input logic                    clk,
  input logic                    rst_n,
  dot_product_sequencer_if.slave bus
);

  localparam logic [ADDR_WIDTH:0]   MAX_LEN = (ADDR_WIDTH + 1)'(VEC_LEN);
  localparam logic [ADDR_WIDTH:0]   LEN_ONE = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH-1:0] IDX_ONE = ADDR_WIDTH'(1);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [ADDR_WIDTH:0]   len_q, len_d;
  logic                  cfg_err_q, cfg_err_d;

  logic                  len_ok, cmd, accept, last_issue;
  logic                  issue, busy, result_valid;
  logic                  pipe_empty;
  logic [ACC_WIDTH-1:0]  acc;

  assign len_ok     = (bus.len != '0) && (bus.len <= MAX_LEN);
  assign cmd        = (state_q == ST_IDLE) && bus.start && bus.mem_ready;
  assign accept     = cmd && len_ok;
  assign last_issue = ({1'b0, idx_q} + LEN_ONE) == len_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q     <= '0;
      len_q     <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      idx_q     <= idx_d;
      len_q     <= len_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    len_d     = len_q;
    cfg_err_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          len_d   = bus.len;
          idx_d   = '0;
          state_d = ST_ISSUE;
        end else if (cmd) begin
          cfg_err_d = 1'b1;
        end
      end
      ST_ISSUE: begin
        if (last_issue) begin
          idx_d   = '0;
          state_d = ST_FLUSH;
        end else begin
          idx_d = idx_q + IDX_ONE;
        end
      end
      // Leaves as the last product is being accumulated, so HOLD sees the final sum.
      ST_FLUSH: if (pipe_empty) state_d = ST_HOLD;
      ST_HOLD:  if (bus.result_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    issue        = (state_q == ST_ISSUE);
    busy         = (state_q != ST_IDLE);
    result_valid = (state_q == ST_HOLD);
  end

  dot_mac_unit #(
    .DATA_WIDTH (DATA_WIDTH),
    .ACC_WIDTH  (ACC_WIDTH)
  ) u_mac (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (accept),
    .data_valid (issue),
    .dout_a     (bus.dout_a),
    .dout_b     (bus.dout_b),
    .acc        (acc),
    .pipe_empty (pipe_empty)
  );

  assign bus.rd_en_a      = issue;
  assign bus.rd_en_b      = issue;
  assign bus.rd_addr_a    = idx_q;
  assign bus.rd_addr_b    = idx_q;
  assign bus.busy         = busy;
  assign bus.cfg_err      = cfg_err_q;
  assign bus.result       = acc;
  assign bus.result_valid = result_valid;

endmodule
